// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Instruction fetch front end. Owns the fetch PC, issues word-addressed
//   requests to instruction memory, buffers returned instructions (tagged with
//   their PC) in an in-order FIFO for decode, and handles redirects from the
//   branch unit by flushing the FIFO and discarding stale in-flight responses.
//
// Ports
//   i_clk, i_rst         clock (rising edge), asynchronous active-high reset
//   i_redirect(_pc)      one-cycle redirect strobe and absolute target PC
//   o_imem_req_*         request channel (valid/addr out, ready in)
//   i_imem_rsp_*         response channel, in request order, no backpressure
//   o_instr_*            FIFO head toward decode (valid/instr/pc), i_instr_ready
// -----------------------------------------------------------------------------
module fetch_unit #(
   parameter int                   REG_WIDTH   = 32,
   parameter int                   INSTR_WIDTH = 32,
   parameter int                   FIFO_DEPTH  = 4,
   parameter logic [REG_WIDTH-1:0] RESET_PC    = '0
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic                   i_redirect,
   input  logic [REG_WIDTH-1:0]   i_redirect_pc,
   output logic                   o_imem_req_valid,
   output logic [REG_WIDTH-1:0]   o_imem_req_addr,
   input  logic                   i_imem_req_ready,
   input  logic                   i_imem_rsp_valid,
   input  logic [INSTR_WIDTH-1:0] i_imem_rsp_data,
   output logic                   o_instr_valid,
   output logic [INSTR_WIDTH-1:0] o_instr,
   output logic [REG_WIDTH-1:0]   o_instr_pc,
   input  logic                   i_instr_ready
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(FIFO_DEPTH);

   logic [REG_WIDTH-1:0]   fetch_pc_q, fetch_pc_d;
   logic [REG_WIDTH-1:0]   rsp_pc_q, rsp_pc_d;
   logic [CNT_W-1:0]       outstanding_q, outstanding_d;
   logic [CNT_W-1:0]       stale_q, stale_d;
   logic [CNT_W-1:0]       count_q, count_d;
   logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;

   logic [REG_WIDTH-1:0]   fifo_pc_q   [FIFO_DEPTH];
   logic [INSTR_WIDTH-1:0] fifo_data_q [FIFO_DEPTH];

   logic credit_ok;
   logic req_valid;
   logic req_fire;
   logic head_valid;
   logic push;
   logic pop;

   // Credits cover both in-flight requests and buffered entries, so every
   // response is guaranteed a FIFO slot when it returns.
   assign credit_ok  = ({1'b0, outstanding_q} + {1'b0, count_q}) < DEPTH_C;
   assign req_valid  = !i_rst && credit_ok && !i_redirect;
   assign req_fire   = req_valid && i_imem_req_ready;
   assign head_valid = (count_q != '0);

   // A redirect discards this cycle's pop and push along with the whole FIFO.
   assign push = i_imem_rsp_valid && (stale_q == '0) && !i_redirect;
   assign pop  = head_valid && i_instr_ready && !i_redirect;

   always_comb begin
      fetch_pc_d    = fetch_pc_q;
      rsp_pc_d      = rsp_pc_q;
      outstanding_d = outstanding_q + CNT_W'(req_fire) - CNT_W'(i_imem_rsp_valid);
      stale_d       = stale_q;
      count_d       = count_q + CNT_W'(push) - CNT_W'(pop);
      wr_ptr_d      = wr_ptr_q;
      rd_ptr_d      = rd_ptr_q;

      if (req_fire) begin
         fetch_pc_d = fetch_pc_q + REG_WIDTH'(1);
      end
      if (i_imem_rsp_valid && (stale_q != '0)) begin
         stale_d = stale_q - CNT_W'(1);
      end
      if (push) begin
         rsp_pc_d = rsp_pc_q + REG_WIDTH'(1);
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end

      if (i_redirect) begin
         fetch_pc_d = i_redirect_pc;
         rsp_pc_d   = i_redirect_pc;
         // No request fires in a redirect cycle, so everything still
         // outstanding after this cycle's response belongs to the old path.
         stale_d    = outstanding_d;
         count_d    = '0;
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         fetch_pc_q    <= RESET_PC;
         rsp_pc_q      <= RESET_PC;
         outstanding_q <= '0;
         stale_q       <= '0;
         count_q       <= '0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
      end else begin
         fetch_pc_q    <= fetch_pc_d;
         rsp_pc_q      <= rsp_pc_d;
         outstanding_q <= outstanding_d;
         stale_q       <= stale_d;
         count_q       <= count_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
      end
   end

   // Storage needs no reset: entries are only visible when counted valid.
   always_ff @(posedge i_clk) begin
      if (push) begin
         fifo_pc_q[wr_ptr_q]   <= rsp_pc_q;
         fifo_data_q[wr_ptr_q] <= i_imem_rsp_data;
      end
   end

   assign o_imem_req_valid = req_valid;
   assign o_imem_req_addr  = fetch_pc_q;
   assign o_instr_valid    = head_valid;
   // Gate the head so the outputs read zero whenever the buffer is empty.
   assign o_instr          = head_valid ? fifo_data_q[rd_ptr_q] : '0;
   assign o_instr_pc       = head_valid ? fifo_pc_q[rd_ptr_q]   : '0;

   // A response with nothing outstanding means the memory side broke protocol.
   rsp_underflow_a : assert property (@(posedge i_clk) disable iff (i_rst)
      !(i_imem_rsp_valid && (outstanding_q == '0)));

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        req_valid;
   logic [31:0] req_addr;
   logic        req_ready;
   logic        rsp_valid;
   logic [31:0] rsp_data;
   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_ready;

   // Second instance: wrapping reset PC, request side only (no responses).
   logic        req_valid_w;
   logic [31:0] req_addr_w;
   logic        rsp_valid_w;
   logic [31:0] rsp_data_w;
   logic        instr_valid_w;
   logic [31:0] instr_w;
   logic [31:0] instr_pc_w;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] mem_q[$];
   bit          rsp_en;

   fetch_unit #(
      .REG_WIDTH(32), .INSTR_WIDTH(32), .FIFO_DEPTH(4), .RESET_PC(32'h0)
   ) dut (
      .i_clk(clk), .i_rst(rst),
      .i_redirect(redirect), .i_redirect_pc(redirect_pc),
      .o_imem_req_valid(req_valid), .o_imem_req_addr(req_addr),
      .i_imem_req_ready(req_ready),
      .i_imem_rsp_valid(rsp_valid), .i_imem_rsp_data(rsp_data),
      .o_instr_valid(instr_valid), .o_instr(instr), .o_instr_pc(instr_pc),
      .i_instr_ready(instr_ready)
   );

   fetch_unit #(
      .REG_WIDTH(32), .INSTR_WIDTH(32), .FIFO_DEPTH(4), .RESET_PC(32'hFFFF_FFFE)
   ) dut_wrap (
      .i_clk(clk), .i_rst(rst),
      .i_redirect(redirect), .i_redirect_pc(redirect_pc),
      .o_imem_req_valid(req_valid_w), .o_imem_req_addr(req_addr_w),
      .i_imem_req_ready(req_ready),
      .i_imem_rsp_valid(rsp_valid_w), .i_imem_rsp_data(rsp_data_w),
      .o_instr_valid(instr_valid_w), .o_instr(instr_w), .o_instr_pc(instr_pc_w),
      .i_instr_ready(instr_ready)
   );

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'hDEAD_BEEF;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
      $display("check %-24s observed %h expected %h", tag, obs, exp);
   endtask

   // Present the oldest accepted request as a response (1-cycle memory).
   task automatic present();
      if (rsp_en && mem_q.size() > 0) begin
         rsp_valid = 1'b1;
         rsp_data  = mem_word(mem_q[0]);
      end else begin
         rsp_valid = 1'b0;
         rsp_data  = '0;
      end
   endtask

   // One clock: sample handshakes mid-cycle, update the memory model after
   // the edge, and return with outputs settled at posedge+2.
   task automatic tick();
      bit          fired;
      bit          consumed;
      logic [31:0] a;
      @(negedge clk);
      fired    = req_valid && req_ready;
      consumed = rsp_valid;
      a        = req_addr;
      @(posedge clk);
      #1;
      if (rst) begin
         mem_q.delete();
      end else begin
         if (consumed) void'(mem_q.pop_front());
         if (fired) mem_q.push_back(a);
      end
      present();
      #1;
   endtask

   task automatic do_reset();
      rst      = 1'b1;
      redirect = 1'b0;
      mem_q.delete();
      rsp_valid = 1'b0;
      rsp_data  = '0;
      @(posedge clk);
      #2;
   endtask

   task automatic release_reset();
      rst = 1'b0;
      #1;
   endtask

   initial begin
      rst         = 1'b1;
      redirect    = 1'b0;
      redirect_pc = '0;
      req_ready   = 1'b1;
      rsp_valid   = 1'b0;
      rsp_data    = '0;
      rsp_valid_w = 1'b0;
      rsp_data_w  = '0;
      instr_ready = 1'b1;
      rsp_en      = 1'b1;

      // ---- 1: reset state, then streaming fetch ----
      do_reset();
      check("t1_rst_req_valid", 32'(req_valid), 32'd0);
      check("t1_rst_req_addr", req_addr, 32'd0);
      check("t1_rst_instr_valid", 32'(instr_valid), 32'd0);
      check("t1_rst_instr", instr, 32'd0);
      check("t1_rst_instr_pc", instr_pc, 32'd0);
      release_reset();
      check("t1_req_valid", 32'(req_valid), 32'd1);
      check("t1_addr0", req_addr, 32'd0);
      tick();
      check("t1_addr1", req_addr, 32'd1);
      check("t1_no_bypass", 32'(instr_valid), 32'd0);
      for (int k = 2; k < 7; k++) begin
         tick();
         check($sformatf("t1_addr%0d", k), req_addr, 32'(k));
         check($sformatf("t1_valid%0d", k), 32'(instr_valid), 32'd1);
         check($sformatf("t1_pc%0d", k), instr_pc, 32'(k - 2));
      end
      check("t1_instr", instr, mem_word(32'd4));

      // ---- 2: decode stalled, credit limit ----
      do_reset();
      instr_ready = 1'b0;
      release_reset();
      repeat (6) tick();
      check("t2_req_valid_full", 32'(req_valid), 32'd0);
      check("t2_addr_held", req_addr, 32'd4);
      check("t2_full_valid", 32'(instr_valid), 32'd1);
      check("t2_head_pc", instr_pc, 32'd0);
      check("t2_head_instr", instr, mem_word(32'd0));
      instr_ready = 1'b1;
      #1;
      tick();
      check("t2_drain_pc", instr_pc, 32'd1);
      check("t2_resume_valid", 32'(req_valid), 32'd1);
      check("t2_resume_addr", req_addr, 32'd4);
      tick();
      check("t2_drain_pc2", instr_pc, 32'd2);
      check("t2_resume_addr2", req_addr, 32'd5);

      // ---- 3: memory not ready holds the request ----
      do_reset();
      req_ready = 1'b0;
      release_reset();
      for (int k = 0; k < 3; k++) begin
         tick();
         check($sformatf("t3_valid_held%0d", k), 32'(req_valid), 32'd1);
         check($sformatf("t3_addr_held%0d", k), req_addr, 32'd0);
      end
      req_ready = 1'b1;
      #1;
      tick();
      check("t3_addr_adv", req_addr, 32'd1);
      tick();
      check("t3_first_pc", instr_pc, 32'd0);

      // ---- 4: redirect with 3 outstanding, one returning that cycle ----
      do_reset();
      rsp_en = 1'b0;
      release_reset();
      repeat (3) tick();
      check("t4_three_out_addr", req_addr, 32'd3);
      req_ready   = 1'b0;
      rsp_en      = 1'b1;
      present();
      redirect    = 1'b1;
      redirect_pc = 32'h40;
      #1;
      check("t4_no_req_on_redir", 32'(req_valid), 32'd0);
      tick();
      redirect  = 1'b0;
      req_ready = 1'b1;
      #1;
      check("t4_empty_after", 32'(instr_valid), 32'd0);
      check("t4_new_addr", req_addr, 32'h40);
      check("t4_req_next_cycle", 32'(req_valid), 32'd1);
      tick();
      check("t4_drop1", 32'(instr_valid), 32'd0);
      tick();
      check("t4_drop2", 32'(instr_valid), 32'd0);
      tick();
      check("t4_target_valid", 32'(instr_valid), 32'd1);
      check("t4_target_pc", instr_pc, 32'h40);
      check("t4_target_instr", instr, mem_word(32'h40));

      // ---- 5: redirect with same-cycle pop and push ----
      do_reset();
      release_reset();
      repeat (3) tick();
      check("t5_pre_pc", instr_pc, 32'd1);
      check("t5_pre_rsp", 32'(rsp_valid), 32'd1);
      redirect    = 1'b1;
      redirect_pc = 32'h100;
      #1;
      tick();
      redirect = 1'b0;
      #1;
      check("t5_flushed", 32'(instr_valid), 32'd0);
      check("t5_addr", req_addr, 32'h100);
      tick();
      check("t5_no_stale", 32'(instr_valid), 32'd0);
      tick();
      check("t5_target_pc", instr_pc, 32'h100);
      check("t5_target_instr", instr, mem_word(32'h100));

      // ---- 6: PC wrap and asynchronous reset mid-burst ----
      do_reset();
      check("t6_rst_addr_w", req_addr_w, 32'hFFFF_FFFE);
      release_reset();
      check("t6_addr_w0", req_addr_w, 32'hFFFF_FFFE);
      tick();
      check("t6_addr_w1", req_addr_w, 32'hFFFF_FFFF);
      tick();
      check("t6_addr_w2", req_addr_w, 32'h0);
      tick();
      check("t6_addr_w3", req_addr_w, 32'h1);
      check("t6_dut_busy", 32'(instr_valid), 32'd1);
      rst = 1'b1;
      #1;
      check("t6_async_req_w", 32'(req_valid_w), 32'd0);
      check("t6_async_addr_w", req_addr_w, 32'hFFFF_FFFE);
      check("t6_async_valid", 32'(instr_valid), 32'd0);
      check("t6_async_instr", instr, 32'd0);
      check("t6_async_pc", instr_pc, 32'd0);
      check("t6_async_addr", req_addr, 32'd0);
      mem_q.delete();
      rsp_valid = 1'b0;
      rsp_data  = '0;
      tick();
      release_reset();
      check("t6_restart_addr_w", req_addr_w, 32'hFFFF_FFFE);
      check("t6_restart_req_w", 32'(req_valid_w), 32'd1);
      tick();
      check("t6_restart_w1", req_addr_w, 32'hFFFF_FFFF);
      check("t6_restart_addr", req_addr, 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
